// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status bundle for consumers of fifo_flags
package fifo_pkg;
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTHxWIDTH dual-port store; clk/we/waddr/wdata sync write, raddr->rdata combinational read
module fifo_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 1024,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: FWFT sync FIFO; clk/rst/flush, wen+din push, pop; dout head, count, empty/full/almost flags, sticky overflow/underflow
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 36,
  parameter int DEPTH    = 1024,
  parameter int ADDR     = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wen,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int CW = ADDR + 1;
  localparam logic [ADDR:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR:0] AF_C = CW'(AF_LEVEL);
  localparam logic [ADDR:0] AE_C = CW'(AE_LEVEL);
  logic [ADDR-1:0] raddr_q, raddr_d, waddr_q, waddr_d, raddr_n;
  logic [ADDR:0] count_q, count_d, count_n;
  logic [WIDTH-1:0] dout_q, dout_d, rd_data;
  fifo_status_t status_q, status_d;
  logic pop_ok, push_acc;
  always_comb begin
    pop_ok = pop && !status_q.empty;
    push_acc = wen && (!status_q.full || pop_ok);
    raddr_n = raddr_q + ADDR'(pop_ok);
    count_n = count_q + CW'(push_acc) - CW'(pop_ok);
    raddr_d = flush ? '0 : raddr_n;
    waddr_d = flush ? '0 : waddr_q + ADDR'(push_acc);
    count_d = flush ? '0 : count_n;
    dout_d = (flush || count_n == '0) ? dout_q :
             (push_acc && waddr_q == raddr_n) ? din : rd_data;
    status_d.empty = count_d == '0;
    status_d.full = count_d == DEPTH_C;
    status_d.almost_empty = count_d <= AE_C;
    status_d.almost_full = count_d >= AF_C;
    status_d.overflow = status_q.overflow || (!flush && wen && !push_acc);
    status_d.underflow = status_q.underflow || (!flush && pop && status_q.empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
      waddr_q <= '0;
      count_q <= '0;
      dout_q <= '0;
      status_q <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0,
                    overflow: 1'b0, underflow: 1'b0};
    end else begin
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      dout_q <= dout_d;
      status_q <= status_d;
    end
  end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_ram (
    .clk(clk),
    .we(push_acc && !flush && !rst),
    .waddr(waddr_q),
    .wdata(din),
    .raddr(raddr_n),
    .rdata(rd_data)
  );
  assign dout = dout_q;
  assign count = count_q;
  assign empty = status_q.empty;
  assign full = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full = status_q.almost_full;
  assign overflow = status_q.overflow;
  assign underflow = status_q.underflow;
endmodule
